// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser slice: command opcodes,
// response bytes and the parser state encoding.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] OP_GCD   = 8'h47;  // 'G'

  localparam logic [7:0] RSP_ACK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_DONE = 8'h44;  // 'D'
  localparam logic [7:0] RSP_ERR  = 8'h45;  // 'E'

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_DO_WRITE,
    ST_DO_READ,
    ST_READ_WAIT,
    ST_SEND_DATA,
    ST_START_GCD,
    ST_WAIT_GCD,
    ST_SEND_RESP
  } parserState_t;

endpackage

// File: rtl/cmd_tx_serializer.sv
// Response serializer: loads either a full DATA_W word or a single byte and
// presents it MSB-first on a valid/ready byte stream.
// Ports:
//   clk, reset     - clock, asynchronous active-low reset
//   loadWord       - load wordIn, DATA_BYTES bytes to send
//   loadByte       - load byteIn, one byte to send
//   txData/txValid - byte stream towards the UART transmitter
//   txReady        - transmitter accepts when txValid & txReady
//   lastSent       - high in the cycle the final byte is handshaken
module cmd_tx_serializer #(
  parameter int DATA_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    loadWord,
  input  logic                    loadByte,
  input  logic [8*DATA_BYTES-1:0] wordIn,
  input  logic [7:0]              byteIn,
  output logic [7:0]              txData,
  output logic                    txValid,
  input  logic                    txReady,
  output logic                    lastSent
);

  localparam int DATA_W = 8 * DATA_BYTES;
  localparam int CNT_W  = $clog2(DATA_BYTES + 1);

  logic [DATA_W-1:0] shiftReg;
  logic [CNT_W-1:0]  bytesLeft;
  logic              validReg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shiftReg  <= '0;
      bytesLeft <= '0;
      validReg  <= 1'b0;
    end else if (loadWord) begin
      shiftReg  <= wordIn;
      bytesLeft <= CNT_W'(DATA_BYTES);
      validReg  <= 1'b1;
    end else if (loadByte) begin
      // Single byte sits in the top lane so the same MSB tap serves both loads.
      shiftReg  <= DATA_W'(byteIn) << (DATA_W - 8);
      bytesLeft <= CNT_W'(1);
      validReg  <= 1'b1;
    end else if (validReg && txReady) begin
      shiftReg  <= shiftReg << 8;
      bytesLeft <= bytesLeft - CNT_W'(1);
      validReg  <= (bytesLeft != CNT_W'(1));
    end
  end

  assign txData   = shiftReg[DATA_W-1 -: 8];
  assign txValid  = validReg;
  assign lastSent = validReg && txReady && (bytesLeft == CNT_W'(1));

endmodule

// File: rtl/uart_command_parser.sv
// Byte-level command interpreter between the UART and the register file /
// GCD engine. Decodes 'W' addr d0..dN (write), 'R' addr (read) and 'G'
// (GCD start); answers with 'K', data bytes, 'D' or 'E'.
// Ports:
//   clk, reset                    - clock, asynchronous active-low reset
//   rx_data/rx_valid/rx_ready     - received byte stream
//   tx_data/tx_valid/tx_ready     - response byte stream
//   reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, reg_rd_data
//                                 - register file port (read data 1 cycle late)
//   gcd_start, gcd_done           - GCD engine one-cycle handshake
//   busy                          - high whenever a command is in progress
module uart_command_parser
  import uart_cmd_pkg::*;
#(
  parameter int DATA_BYTES     = 4,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 12000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [ADDR_W-1:0]       reg_addr,
  output logic                    reg_wr_en,
  output logic [8*DATA_BYTES-1:0] reg_wr_data,
  output logic                    reg_rd_en,
  input  logic [8*DATA_BYTES-1:0] reg_rd_data,
  output logic                    gcd_start,
  input  logic                    gcd_done,
  output logic                    busy
);

  localparam int DATA_W = 8 * DATA_BYTES;
  localparam int BC_W   = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES);

  parserState_t      state, nextState;
  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] dataReg;
  logic              isWrite;
  logic [BC_W-1:0]   byteCnt;
  logic [TO_W-1:0]   idleCnt;
  logic              rxAccept, timedOut, lastByte;
  logic              loadWord, loadByte, lastSent;
  logic [7:0]        respByte;

  assign rxAccept = rx_valid && rx_ready;
  assign timedOut = (idleCnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign lastByte = (byteCnt == BC_W'(DATA_BYTES - 1));

  always_comb begin
    nextState = state;
    rx_ready  = 1'b0;
    reg_wr_en = 1'b0;
    reg_rd_en = 1'b0;
    gcd_start = 1'b0;
    loadWord  = 1'b0;
    loadByte  = 1'b0;
    respByte  = RSP_ERR;
    case (state)
      ST_IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (rx_data == OP_WRITE || rx_data == OP_READ) begin
            nextState = ST_GET_ADDR;
          end else if (rx_data == OP_GCD) begin
            nextState = ST_START_GCD;
          end else begin
            nextState = ST_SEND_RESP;
            loadByte  = 1'b1;
          end
        end
      end
      ST_GET_ADDR: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          nextState = isWrite ? ST_GET_DATA : ST_DO_READ;
        end else if (timedOut) begin
          nextState = ST_SEND_RESP;
          loadByte  = 1'b1;
        end
      end
      ST_GET_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (lastByte) nextState = ST_DO_WRITE;
        end else if (timedOut) begin
          nextState = ST_SEND_RESP;
          loadByte  = 1'b1;
        end
      end
      ST_DO_WRITE: begin
        reg_wr_en = 1'b1;
        nextState = ST_SEND_RESP;
        loadByte  = 1'b1;
        respByte  = RSP_ACK;
      end
      ST_DO_READ: begin
        reg_rd_en = 1'b1;
        nextState = ST_READ_WAIT;
      end
      ST_READ_WAIT: begin
        loadWord  = 1'b1;
        nextState = ST_SEND_DATA;
      end
      ST_SEND_DATA, ST_SEND_RESP: begin
        if (lastSent) nextState = ST_IDLE;
      end
      ST_START_GCD: begin
        gcd_start = 1'b1;
        nextState = ST_WAIT_GCD;
      end
      ST_WAIT_GCD: begin
        if (gcd_done) begin
          nextState = ST_SEND_RESP;
          loadByte  = 1'b1;
          respByte  = RSP_DONE;
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      addrReg <= '0;
      dataReg <= '0;
      isWrite <= 1'b0;
      byteCnt <= '0;
      idleCnt <= '0;
    end else begin
      state <= nextState;
      if (rxAccept) begin
        case (state)
          ST_IDLE: isWrite <= (rx_data == OP_WRITE);
          ST_GET_ADDR: begin
            addrReg <= ADDR_W'(rx_data);
            dataReg <= '0;
            byteCnt <= '0;
          end
          ST_GET_DATA: begin
            dataReg <= (dataReg << 8) | DATA_W'(rx_data);
            byteCnt <= byteCnt + BC_W'(1);
          end
          default: ;
        endcase
      end
      // Entry into GET_ADDR/GET_DATA always follows an accepted byte, so
      // clearing on accept also covers the clear-on-entry case.
      if (rxAccept || (state != ST_GET_ADDR && state != ST_GET_DATA))
        idleCnt <= '0;
      else
        idleCnt <= idleCnt + TO_W'(1);
    end
  end

  cmd_tx_serializer #(
    .DATA_BYTES(DATA_BYTES)
  ) u_txSer (
    .clk      (clk),
    .reset    (reset),
    .loadWord (loadWord),
    .loadByte (loadByte),
    .wordIn   (reg_rd_data),
    .byteIn   (respByte),
    .txData   (tx_data),
    .txValid  (tx_valid),
    .txReady  (tx_ready),
    .lastSent (lastSent)
  );

  assign reg_addr    = addrReg;
  assign reg_wr_data = dataReg;
  assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_command_parser.sv
module tb_uart_command_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  reg_addr;
  logic        reg_wr_en;
  logic [31:0] reg_wr_data;
  logic        reg_rd_en;
  logic [31:0] reg_rd_data;
  logic        gcd_start;
  logic        gcd_done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  int          wrCount = 0;
  int          rdCount = 0;
  int          gcdCount = 0;
  logic [7:0]  lastWrAddr;
  logic [31:0] lastWrData;
  logic [31:0] mem [256];

  always #5 clk = ~clk;

  uart_command_parser #(
    .DATA_BYTES(4),
    .ADDR_W(8),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
    .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
    .gcd_start(gcd_start), .gcd_done(gcd_done), .busy(busy)
  );

  // Bench-side register file with one-cycle read latency plus strobe counters.
  always @(posedge clk) begin
    if (reg_rd_en) begin
      reg_rd_data <= mem[reg_addr];
      rdCount <= rdCount + 1;
    end
    if (reg_wr_en) begin
      mem[reg_addr] <= reg_wr_data;
      lastWrAddr <= reg_addr;
      lastWrData <= reg_wr_data;
      wrCount <= wrCount + 1;
    end
    if (gcd_start) gcdCount <= gcdCount + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      step();
      n++;
    end
    chk("rx_ready before send", rx_ready, 1);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic recvByte(input string tag, input logic [7:0] exp, input int stall);
    int n = 0;
    while (!tx_valid && n < 200) begin
      step();
      n++;
    end
    chk({tag, " valid"}, tx_valid, 1);
    for (int i = 0; i < stall; i++) begin
      step();
      chk({tag, " stalled"}, {tx_valid, tx_data}, {1'b1, exp});
    end
    chk({tag, " data"}, tx_data, exp);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
  endtask

  initial begin
    int wr0, rd0, gc0;
    logic [31:0] word;
    logic sawTx;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[5] = 32'h12345678;
    mem[0] = 32'hCAFEF00D;
    reset = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0; gcd_done = 1'b0;
    reg_rd_data = 32'h0;

    // Reset state
    step(); step();
    chk("reset rx_ready", rx_ready, 1);
    chk("reset tx_valid", tx_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset strobes", {reg_wr_en, reg_rd_en, gcd_start}, 3'b000);
    chk("reset reg_addr", reg_addr, 8'h00);
    chk("reset tx_data", tx_data, 8'h00);
    reset = 1'b1;
    step();

    // Write 57 03 DE AD BE EF
    wr0 = wrCount;
    sendByte(8'h57);
    chk("write busy", busy, 1);
    sendByte(8'h03);
    sendByte(8'hDE); sendByte(8'hAD); sendByte(8'hBE); sendByte(8'hEF);
    chk("write wr_en", reg_wr_en, 1);
    chk("write addr", reg_addr, 8'h03);
    chk("write data", reg_wr_data, 32'hDEADBEEF);
    chk("write tx early", tx_valid, 0);
    step();
    chk("write wr_en pulse", reg_wr_en, 0);
    chk("write ack latency", {tx_valid, tx_data}, {1'b1, 8'h4B});
    recvByte("write ack", 8'h4B, 0);
    chk("write tx drop", tx_valid, 0);
    chk("write idle", busy, 0);
    chk("write count", wrCount - wr0, 1);
    chk("write mem", mem[3], 32'hDEADBEEF);

    // Read 52 05 with 3-cycle backpressure per byte
    rd0 = rdCount;
    sendByte(8'h52);
    sendByte(8'h05);
    chk("read rd_en", reg_rd_en, 1);
    chk("read addr", reg_addr, 8'h05);
    step();
    chk("read rd_en pulse", reg_rd_en, 0);
    chk("read tx early", tx_valid, 0);
    step();
    chk("read first latency", {tx_valid, tx_data}, {1'b1, 8'h12});
    word = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) chk("read back-to-back", tx_valid, 1);
      recvByte("read byte", word[31-8*i -: 8], 3);
    end
    chk("read tx drop", tx_valid, 0);
    chk("read idle", busy, 0);
    chk("read count", rdCount - rd0, 1);

    // GCD with a done pulse coincident with start (ignored)
    gc0 = gcdCount;
    sendByte(8'h47);
    chk("gcd start", gcd_start, 1);
    chk("gcd rx_ready", rx_ready, 0);
    gcd_done = 1'b1;
    step();
    gcd_done = 1'b0;
    chk("gcd start pulse", gcd_start, 0);
    for (int i = 0; i < 49; i++) step();
    chk("gcd waiting", {busy, rx_ready, tx_valid}, 3'b100);
    chk("gcd start count", gcdCount - gc0, 1);
    gcd_done = 1'b1;
    step();
    gcd_done = 1'b0;
    chk("gcd resp", {tx_valid, tx_data}, {1'b1, 8'h44});
    recvByte("gcd done", 8'h44, 0);
    gcd_done = 1'b1;
    step();
    gcd_done = 1'b0;
    step();
    chk("stray done", {busy, tx_valid}, 2'b00);

    // Bad opcode then a normal read of address 0
    wr0 = wrCount; rd0 = rdCount; gc0 = gcdCount;
    sendByte(8'h41);
    chk("bad op resp", {tx_valid, tx_data}, {1'b1, 8'h45});
    recvByte("bad op", 8'h45, 0);
    chk("bad op quiet", {wrCount - wr0, rdCount - rd0, gcdCount - gc0}, 96'h0);
    sendByte(8'h52);
    sendByte(8'h00);
    word = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) recvByte("read0 byte", word[31-8*i -: 8], 0);
    chk("read0 idle", busy, 0);

    // Timeout in the middle of a write
    wr0 = wrCount;
    sendByte(8'h57); sendByte(8'h01); sendByte(8'hAA);
    for (int i = 0; i < 19; i++) step();
    chk("timeout early", {tx_valid, busy}, 2'b01);
    step();
    chk("timeout resp", {tx_valid, tx_data}, {1'b1, 8'h45});
    recvByte("timeout", 8'h45, 0);
    chk("timeout no write", wrCount - wr0, 0);
    sendByte(8'h57); sendByte(8'h07);
    sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04);
    recvByte("post-timeout ack", 8'h4B, 0);
    chk("post-timeout count", wrCount - wr0, 1);
    chk("post-timeout addr", lastWrAddr, 8'h07);
    chk("post-timeout data", lastWrData, 32'h01020304);

    // Reset mid-frame
    wr0 = wrCount;
    sendByte(8'h57); sendByte(8'h01); sendByte(8'hAA); sendByte(8'hBB);
    reset = 1'b0;
    #1;
    chk("midreset outputs", {rx_ready, busy, tx_valid, reg_wr_en, reg_rd_en, gcd_start}, 6'b100000);
    chk("midreset addr", reg_addr, 8'h00);
    step(); step();
    reset = 1'b1;
    sawTx = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (tx_valid || busy) sawTx = 1'b1;
    end
    chk("midreset quiet", {sawTx, 32'(wrCount - wr0)}, 33'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_command_parser.md
Name: uart_command_parser

Overview:
- Byte-level command interpreter between the UART receiver/transmitter and the register file / GCD engine.
- Consumes received bytes and decodes write, read and GCD-start commands.
- Drives the register file port and the GCD start/done handshake, and emits response bytes to the UART transmitter.
- One command in flight at a time.

Parameters:
- DATA_BYTES, 4, register width in bytes; DATA_W = 8*DATA_BYTES.
- ADDR_W, 8, register address width; the address is carried in one byte, upper bits beyond ADDR_W ignored.
- TIMEOUT_CYCLES, 12000000, max idle cycles between bytes of one frame (1 s at 12 MHz); minimum 2.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid; held until accepted.
- rx_ready  out  1  parser accepts byte this cycle when rx_valid&rx_ready.
- tx_data  out  8  response byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts when tx_valid&tx_ready.
- reg_addr  out  ADDR_W  register address.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_wr_data  out  DATA_W  write data.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_rd_data  in  DATA_W  read data, valid exactly 1 cycle after reg_rd_en.
- gcd_start  out  1  one-cycle start pulse.
- gcd_done  in  1  one-cycle completion pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset low, async): state IDLE, all outputs 0 except rx_ready=1, internal counters/shift registers cleared. Reset mid-frame discards the frame; no response.
- Opcodes: 0x57 'W' write, 0x52 'R' read, 0x47 'G' GCD. Responses: 0x4B 'K' write ack, 0x44 'D' GCD done, 0x45 'E' error.
- rx_ready = 1 only in IDLE, GET_ADDR, GET_DATA; 0 elsewhere (backpressure, no bytes dropped).
- States and transitions:
  - IDLE: on accepted byte, 'W'/'R' -> GET_ADDR; 'G' -> START_GCD; any other value -> SEND_RESP('E').
  - GET_ADDR: accept addr. 'R' -> DO_READ; 'W' -> GET_DATA with byte counter = 0.
  - GET_DATA: shift bytes MSB-first into data register; after DATA_BYTES bytes -> DO_WRITE.
  - DO_WRITE: reg_wr_en=1 for one cycle with addr/data stable -> SEND_RESP('K').
  - DO_READ: reg_rd_en=1 one cycle -> READ_WAIT.
  - READ_WAIT: capture reg_rd_data into the tx shift register -> SEND_DATA.
  - SEND_DATA: present DATA_BYTES bytes MSB-first; advance on tx handshake; after last -> IDLE.
  - START_GCD: gcd_start=1 one cycle -> WAIT_GCD.
  - WAIT_GCD: wait indefinitely for gcd_done -> SEND_RESP('D').
  - SEND_RESP: tx_valid=1 with the response byte until the handshake -> IDLE.
- tx_data/tx_valid are stable while tx_valid & !tx_ready; tx_valid deasserts the cycle after the handshake unless another byte follows in SEND_DATA, in which case the next byte is presented back-to-back.
- Timeout: counter runs in GET_ADDR/GET_DATA, cleared on every accepted byte and on state entry. Reaching TIMEOUT_CYCLES -> SEND_RESP('E'); partial data is discarded and no register write occurs.
- gcd_done outside WAIT_GCD is ignored. A gcd_done coincident with gcd_start is ignored.
- reg_addr holds its last value between commands. reg_wr_data is valid only during reg_wr_en.
- The address byte is truncated to ADDR_W bits; when ADDR_W > 8 it is zero-extended.
- Latency:
  - Write: last data byte accepted -> reg_wr_en next cycle -> 'K' tx_valid the following cycle.
  - Read: addr accepted -> reg_rd_en next cycle -> first tx_valid 2 cycles after reg_rd_en.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - opcode constants OP_WRITE/OP_READ/OP_GCD;
  - response constants RSP_ACK/RSP_DONE/RSP_ERR;
  - the parser state enum.
- One sub-module, cmd_tx_serializer:
  - loads a DATA_W word or a single byte;
  - shifts bytes out MSB-first over the tx valid/ready handshake;
  - signals last-byte-sent.

Test Plan:
- Write: bytes 57 03 DE AD BE EF -> one reg_wr_en, reg_addr=0x03, reg_wr_data=0xDEADBEEF; tx 0x4B; busy back to 0.
- Read with backpressure: reg_rd_data=0x12345678 at addr 0x05; bytes 52 05; tx_ready low 3 cycles per byte -> tx 12 34 56 78, tx_data stable while stalled, exactly one reg_rd_en.
- GCD: byte 47 -> single gcd_start pulse; rx_ready=0 during wait; gcd_done after 50 cycles -> tx 0x44; stray gcd_done while IDLE -> no output.
- Bad opcode: byte 0x41 -> tx 0x45, no register or GCD activity; next frame 52 00 processed normally.
- Timeout (TIMEOUT_CYCLES=20): bytes 57 01 AA then silence -> tx 0x45 at cycle 20 after AA, no reg_wr_en; a following full write succeeds.
- Reset mid-frame: assert reset after 57 01 AA BB -> outputs immediately 0, rx_ready=1; no write or response after release.
